sao_deci_ctrl: RTL
==================

# sao_deci_ctrl

SAO decision-stage controller, directly downstream of the SAO statistics FSM. When a component's statistics are complete, it reads the per-category counts and difference sums from the statistics buffer. It searches for the best clipped offset for each category and picks the lowest-cost SAO type (OFF, EO0–EO3, BO). While it runs, it drives `isWorking_deci` back to the statistics stage, which clears that stage's end flags.

## Interface
Parameters:
- `MAX_OFF`, 7: largest offset magnitude searched (8-bit video).
- `CNT_W`, 12: width of the per-category sample count.
- `SUM_W`, 18: width of the signed per-category sum of (orig − rec).
- `LAMBDA_W`, 16: width of the unsigned rate weight.
- `COST_W`, 26: width of the signed accumulated cost.

Ports:
- `clk` in 1: clock.
- `arst_n` in 1: asynchronous active-low reset. This is the block's only reset; the block has one clock.
- `en_o` in 1: global advance. When low, every register holds its value.
- `stat_done` in 1: one-cycle pulse; the statistics for `stat_cIdx` are complete.
- `stat_cIdx` in 2: component of the current run (0 = luma, 1 = Cb, 2 = Cr). Latched on start.
- `lambda` in LAMBDA_W: rate weight per unit offset magnitude. Latched on start.
- `rd_en` out 1: statistics read strobe.
- `rd_type` out 3: type being read (0–3 = EO0–EO3, 4 = BO).
- `rd_cat` out 2: category or band being read (0–3).
- `rd_cnt` in CNT_W: count returned one enabled cycle after `rd_en`, held until the next `rd_en`.
- `rd_sum` in SUM_W signed: sum returned with the same timing as `rd_cnt`.
- `isWorking_deci` out 1: high in every state except IDLE.
- `deci_done` out 1: one-cycle pulse when the results are valid.
- `deci_cIdx` out 2: latched component of the finished run.
- `sao_type` out 3: 0 = OFF, 1–4 = EO0–EO3, 5 = BO.
- `sao_off0`..`sao_off3` out 4 signed each: chosen offsets. All are 0 when `sao_type` is OFF.

## Operation
- FSM states: IDLE, REQ, WAIT, SRCH, ACC, CMP, DONE.
- **IDLE**
  - A `stat_done` pulse latches `stat_cIdx` and `lambda`, clears the type index t, the category c and `best_cost`, sets `best_type` to OFF, and moves to REQ.
  - `stat_done` is ignored in every other state.
- **REQ**: `rd_en`=1, `rd_type`=t, `rd_cat`=c. Next state is WAIT.
- **WAIT**: captures `rd_cnt` and `rd_sum`. It also selects the sign s:
  - EO categories 0 and 1: s = +1.
  - EO categories 2 and 3: s = −1.
  - BO: s = +1 if `rd_sum` ≥ 0, otherwise −1.
  - Sets k = 0 and `cat_best` = 0 with `cat_k` = 0, then moves to SRCH.
- **SRCH**: one cycle per k, for k = 1..MAX_OFF.
  - cost(k) = cnt·k² − 2·k·s·sum + lambda·k.
  - If cost(k) < `cat_best` (strict), update `cat_best` and `cat_k`. On ties the smaller k wins.
  - After k = MAX_OFF, move to ACC.
- **ACC**
  - `type_cost` += `cat_best`, and the offset for category c of this type is s·`cat_k`.
  - If c < 3: c++ and go to REQ. Otherwise go to CMP.
- **CMP**
  - If `type_cost` < `best_cost` (strict), update `best_cost`, `best_type` and the best offsets. On ties the lower type index wins, and OFF beats everything.
  - Clear `type_cost` and set c = 0.
  - If t < 4: t++ and go to REQ. Otherwise go to DONE.
- **DONE**: pulses `deci_done`, drives the `sao_*` outputs from the best registers, and returns to IDLE.
- Arithmetic:
  - All products are computed at full precision.
  - cnt·k² fits 18 bits, 2·k·|sum| fits 21 bits and lambda·k fits 19 bits, so costs sign-extend into COST_W without overflow.
- Output hold: `sao_*` and `deci_cIdx` hold from DONE until the next DONE.

## Timing
- Reset values: state IDLE.
  - 0 on all outputs: `rd_en`, `rd_type`, `rd_cat`, `isWorking_deci`, `deci_done`, `deci_cIdx`, `sao_type`, `sao_off0`..`sao_off3`.
- Cycle budget:
  - Per category: REQ 1 + WAIT 1 + SRCH MAX_OFF + ACC 1 = 10 cycles (MAX_OFF = 7).
  - Per type: 4 categories + CMP 1 = 41 cycles.
  - 5 types = 205 cycles.
- `stat_done` sampled in cycle 0 gives:
  - `isWorking_deci` high in cycles 1–206.
  - `deci_done` high in cycle 206 only.
  - `isWorking_deci` low in cycle 207.
- `en_o` low stalls the FSM and all counters, and adds exactly one cycle per stalled cycle. `deci_done` stays high for the whole stall if the stall hits DONE.
- `stat_done` arriving during DONE is ignored. The next run may start from cycle 207 onward.
- `arst_n` asserted mid-run returns the block to IDLE immediately and clears all outputs. No `deci_done` is issued for the aborted run.

## Test plan
- **All-zero statistics**: start with lambda = 0.
  - `deci_done` at cycle 206.
  - `sao_type` = 0 and all offsets 0.
- **EO0 category 0**: cnt = 100, sum = 300, lambda = 0; every other read returns 0.
  - cost(3) = −900 is the minimum (k = 2 and k = 4 give −800).
  - Expect `sao_type` = 1 and offsets {3, 0, 0, 0}.
- **Sign constraint and clipping on EO2**:
  - Category 0: cnt = 50, sum = −200. Expect offset 0.
  - Category 2: cnt = 50, sum = −500. Expect offset −7, cost −4550.
  - Expect `sao_type` = 3.
- **Lambda and tie rule**: EO0 category 0 with cnt = 100, sum = 300, lambda = 200.
  - k = 1 and k = 3 both cost −300; k = 2 costs −400.
  - Expect offset +2.
  - Repeat the identical statistics under EO1 as well. Expect `sao_type` = 1 (lower index wins the tie).
- **BO with negative sum**: band 1 with cnt = 10, sum = −40. Expect `sao_type` = 5 and `sao_off1` = −4.
- **Stall and reset**:
  - Hold `en_o` low for 10 cycles mid-run. Expect `deci_done` at cycle 216 with unchanged results.
  - Assert `arst_n` at cycle 100. Expect all outputs 0, no `deci_done`, and a correct fresh run on the next `stat_done`.

Source files
------------

// File: rtl/sao_deci_ctrl.sv
// -----------------------------------------------------------------------------
// sao_deci_ctrl
//
// SAO decision stage. Once the statistics stage reports a component complete,
// this block walks every (type, category) pair of the statistics buffer. For
// each category it searches offsets 1..MAX_OFF in the allowed sign direction,
// accumulates the best per-category cost into a per-type cost, and keeps the
// cheapest SAO type (OFF, EO0..EO3, BO) with its four offsets.
//
// Ports
//   clk, arst_n        : clock, asynchronous active-low reset
//   en_o               : global advance; low freezes every register
//   stat_done          : one-cycle start pulse (honoured in IDLE only)
//   stat_cIdx, lambda  : component index and rate weight, latched on start
//   rd_en/rd_type/rd_cat : statistics read request (type 0-3 EO, 4 BO)
//   rd_cnt, rd_sum     : statistics returned one enabled cycle after rd_en
//   isWorking_deci     : high whenever the FSM is not IDLE
//   deci_done          : result-valid strobe (held high if stalled in DONE)
//   deci_cIdx          : component of the finished run
//   sao_type           : 0 OFF, 1-4 EO0-EO3, 5 BO
//   sao_off0..3        : chosen signed offsets, all zero for OFF
// -----------------------------------------------------------------------------
module sao_deci_ctrl #(
    parameter int MAX_OFF  = 7,
    parameter int CNT_W    = 12,
    parameter int SUM_W    = 18,
    parameter int LAMBDA_W = 16,
    parameter int COST_W   = 26
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       en_o,
    input  logic                       stat_done,
    input  logic [1:0]                 stat_cIdx,
    input  logic [LAMBDA_W-1:0]        lambda,
    output logic                       rd_en,
    output logic [2:0]                 rd_type,
    output logic [1:0]                 rd_cat,
    input  logic [CNT_W-1:0]           rd_cnt,
    input  logic signed [SUM_W-1:0]    rd_sum,
    output logic                       isWorking_deci,
    output logic                       deci_done,
    output logic [1:0]                 deci_cIdx,
    output logic [2:0]                 sao_type,
    output logic signed [3:0]          sao_off0,
    output logic signed [3:0]          sao_off1,
    output logic signed [3:0]          sao_off2,
    output logic signed [3:0]          sao_off3
);

    localparam int         K_W   = $clog2(MAX_OFF + 1);
    localparam int         OFF_W = 4;
    localparam int         SS_W  = SUM_W + 1;   // room for negating the most negative sum
    localparam logic [2:0] T_BO  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SRCH,
        S_ACC,
        S_CMP,
        S_DONE
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                      state_q, state_d;
    logic [2:0]                  t_q, t_d;
    logic [1:0]                  c_q, c_d;
    logic [K_W-1:0]              k_q, k_d;
    logic [1:0]                  cidx_q, cidx_d;
    logic [LAMBDA_W-1:0]         lambda_q, lambda_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [SS_W-1:0]      ssum_q, ssum_d;     // s * sum of the current category
    logic                        neg_q, neg_d;       // s == -1
    logic signed [COST_W-1:0]    cat_best_q, cat_best_d;
    logic [K_W-1:0]              cat_k_q, cat_k_d;
    logic signed [COST_W-1:0]    type_cost_q, type_cost_d;
    logic signed [COST_W-1:0]    best_cost_q, best_cost_d;
    logic [2:0]                  best_type_q, best_type_d;
    logic [3:0][OFF_W-1:0]       best_off_q, best_off_d;
    logic [3:0][OFF_W-1:0]       cur_off_q, cur_off_d;
    logic                        rd_en_q, rd_en_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [1:0]                  deci_cidx_q, deci_cidx_d;
    logic [2:0]                  sao_type_q, sao_type_d;
    logic [3:0][OFF_W-1:0]       sao_off_q, sao_off_d;

    // ------------------------------------------------------- datapath terms
    logic                        wait_neg;
    logic signed [SS_W-1:0]      sum_ext;
    logic [K_W:0]                next_k;
    logic signed [COST_W-1:0]    cnt_x, ssum_x, lam_x, k_x, cost_k;
    logic [OFF_W-1:0]            acc_mag;

    // EO categories 0/1 are positive-offset classes, 2/3 negative; BO follows
    // the sign of the accumulated difference.
    assign wait_neg = (t_q == T_BO) ? rd_sum[SUM_W-1] : c_q[1];
    assign sum_ext  = SS_W'(rd_sum);
    assign acc_mag  = OFF_W'(cat_k_q);

    // cost(k) = cnt*k^2 - 2*k*(s*sum) + lambda*k. Every term is bounded well
    // inside COST_W, so evaluating at COST_W is exact.
    always_comb begin
        next_k = {1'b0, k_q} + (K_W + 1)'(1);
        cnt_x  = COST_W'(cnt_q);
        ssum_x = COST_W'(ssum_q);
        lam_x  = COST_W'(lambda_q);
        k_x    = COST_W'(next_k);
        cost_k = cnt_x * k_x * k_x - (k_x + k_x) * ssum_x + lam_x * k_x;
    end

    // ------------------------------------------------------ next-state logic
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        t_d         = t_q;
        c_d         = c_q;
        k_d         = k_q;
        cidx_d      = cidx_q;
        lambda_d    = lambda_q;
        cnt_d       = cnt_q;
        ssum_d      = ssum_q;
        neg_d       = neg_q;
        cat_best_d  = cat_best_q;
        cat_k_d     = cat_k_q;
        type_cost_d = type_cost_q;
        best_cost_d = best_cost_q;
        best_type_d = best_type_q;
        best_off_d  = best_off_q;
        cur_off_d   = cur_off_q;
        deci_cidx_d = deci_cidx_q;
        sao_type_d  = sao_type_q;
        sao_off_d   = sao_off_q;

        case (state_q)
            S_IDLE: begin
                if (stat_done) begin
                    cidx_d      = stat_cIdx;
                    lambda_d    = lambda;
                    t_d         = '0;
                    c_d         = '0;
                    type_cost_d = '0;
                    best_cost_d = '0;      // OFF costs nothing
                    best_type_d = '0;
                    best_off_d  = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d      = rd_cnt;
                neg_d      = wait_neg;
                ssum_d     = wait_neg ? -sum_ext : sum_ext;
                k_d        = '0;
                cat_best_d = '0;           // k = 0 baseline
                cat_k_d    = '0;
                state_d    = S_SRCH;
            end
            S_SRCH: begin
                // Strict compare: on equal cost the earlier (smaller) k stays.
                if (cost_k < cat_best_q) begin
                    cat_best_d = cost_k;
                    cat_k_d    = next_k[K_W-1:0];
                end
                k_d = next_k[K_W-1:0];
                if (next_k == (K_W + 1)'(MAX_OFF)) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                type_cost_d    = type_cost_q + cat_best_q;
                cur_off_d[c_q] = neg_q ? (OFF_W'(0) - acc_mag) : acc_mag;
                if (c_q == 2'd3) begin
                    state_d = S_CMP;
                end else begin
                    c_d     = c_q + 2'd1;
                    state_d = S_REQ;
                end
            end
            S_CMP: begin
                // Strict compare: lower type index (and OFF) wins ties.
                if (type_cost_q < best_cost_q) begin
                    best_cost_d = type_cost_q;
                    best_type_d = t_q + 3'd1;
                    best_off_d  = cur_off_q;
                end
                type_cost_d = '0;
                c_d         = '0;
                if (t_q == T_BO) begin
                    state_d = S_DONE;
                end else begin
                    t_d     = t_q + 3'd1;
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered against the state being entered, so they
        // line up with the state register cycle for cycle.
        rd_en_d = (state_d == S_REQ);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        if (state_d == S_DONE) begin
            deci_cidx_d = cidx_q;
            sao_type_d  = best_type_d;
            sao_off_d   = best_off_d;
        end
    end

    // --------------------------------------------------------------- flops
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            cidx_q      <= '0;
            lambda_q    <= '0;
            cnt_q       <= '0;
            ssum_q      <= '0;
            neg_q       <= 1'b0;
            cat_best_q  <= '0;
            cat_k_q     <= '0;
            type_cost_q <= '0;
            best_cost_q <= '0;
            best_type_q <= '0;
            best_off_q  <= '0;
            cur_off_q   <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            deci_cidx_q <= '0;
            sao_type_q  <= '0;
            sao_off_q   <= '0;
        end else if (en_o) begin
            state_q     <= state_d;
            t_q         <= t_d;
            c_q         <= c_d;
            k_q         <= k_d;
            cidx_q      <= cidx_d;
            lambda_q    <= lambda_d;
            cnt_q       <= cnt_d;
            ssum_q      <= ssum_d;
            neg_q       <= neg_d;
            cat_best_q  <= cat_best_d;
            cat_k_q     <= cat_k_d;
            type_cost_q <= type_cost_d;
            best_cost_q <= best_cost_d;
            best_type_q <= best_type_d;
            best_off_q  <= best_off_d;
            cur_off_q   <= cur_off_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            deci_cidx_q <= deci_cidx_d;
            sao_type_q  <= sao_type_d;
            sao_off_q   <= sao_off_d;
        end
    end

    // ------------------------------------------------------------- outputs
    assign rd_en          = rd_en_q;
    assign rd_type        = t_q;
    assign rd_cat         = c_q;
    assign isWorking_deci = busy_q;
    assign deci_done      = done_q;
    assign deci_cIdx      = deci_cidx_q;
    assign sao_type       = sao_type_q;
    assign sao_off0       = sao_off_q[0];
    assign sao_off1       = sao_off_q[1];
    assign sao_off2       = sao_off_q[2];
    assign sao_off3       = sao_off_q[3];

endmodule
